// File: rtl/mult_iter.sv
// Iterative signed WIDTHxWIDTH radix-2 Booth multiplier; clr doubles as start.
// Optional MULT_HI_EN adds result_hi (upper half of the product).
module mult_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
`ifdef MULT_HI_EN
  output logic [WIDTH-1:0] result_hi,
`endif
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic             ready
);

  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(WIDTH + 1);

  typedef enum logic [1:0] {S_LOAD, S_STEP, S_DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH:0]   a_r, m_r, a_sum;
  logic [WIDTH-1:0] q_r;
  logic             q_m1;
  logic [WIDTH:0]   p_top;

  // Counter is the state register; state is a pure decode of it
  always_ff @(posedge clk or posedge clr) begin
    if (clr) cnt <= '0;
    else     cnt <= cnt_nxt;
  end

  always_comb begin
    state = S_STEP;
    if (cnt == '0)            state = S_LOAD;
    else if (cnt == CNT_DONE) state = S_DONE;
  end

  always_comb begin
    cnt_nxt = cnt;
    if (state != S_DONE) cnt_nxt = cnt + 1'b1;
  end

  // Booth add/sub selection on {Q[0], q_m1}
  always_comb begin
    a_sum = a_r;
    case ({q_r[0], q_m1})
      2'b01:   a_sum = a_r + m_r;
      2'b10:   a_sum = a_r - m_r;
      default: a_sum = a_r;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      a_r  <= '0;
      q_r  <= '0;
      q_m1 <= 1'b0;
      m_r  <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          a_r  <= '0;
          q_r  <= multiplier;
          q_m1 <= 1'b0;
          m_r  <= {multiplicand[WIDTH-1], multiplicand};
        end
        S_STEP: begin
          a_r  <= {a_sum[WIDTH], a_sum[WIDTH:1]};
          q_r  <= {a_sum[0], q_r[WIDTH-1:1]};
          q_m1 <= q_r[0];
        end
        default: ;
      endcase
    end
  end

  // Product fits in WIDTH signed bits iff P[2W-1:W-1] is all-0 or all-1
  assign p_top = {a_r[WIDTH-1:0], q_r[WIDTH-1]};

  always_comb begin
    ready     = (state == S_DONE);
    result    = '0;
    exception = 1'b0;
`ifdef MULT_HI_EN
    result_hi = '0;
`endif
    if (ready) begin
      result    = q_r;
      exception = !((p_top == '0) || (p_top == '1));
`ifdef MULT_HI_EN
      result_hi = a_r[WIDTH-1:0];
`endif
    end
  end

endmodule

// File: tb/tb_mult_iter.sv
// Directed self-checking bench for mult_iter: latency, products, overflow, abort.
module tb_mult_iter;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] multiplicand = '0;
  logic [31:0] multiplier = '0;
  logic [31:0] result;
  logic        exception;
  logic        ready;
`ifdef MULT_HI_EN
  logic [31:0] result_hi;
`endif

  int checks = 0;
  int errors = 0;

  mult_iter #(.WIDTH(32), .CNT_W(6)) dut (
    .clk          (clk),
    .clr          (clr),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
`ifdef MULT_HI_EN
    .result_hi    (result_hi),
`endif
    .result       (result),
    .exception    (exception),
    .ready        (ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulse clr, release on a falling edge, run 33 edges checking ready timing.
  // Operands are scrambled after the load edge to prove they are not re-sampled.
  task automatic run(input string tag, input logic [31:0] m, input logic [31:0] q);
    multiplicand = m;
    multiplier   = q;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int i = 1; i <= 33; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        multiplicand = $urandom;
        multiplier   = $urandom;
        chk({tag, "_rdy_e1"}, {31'b0, ready}, 32'd0);
      end
      if (i == 32) begin
        chk({tag, "_rdy_e32"}, {31'b0, ready}, 32'd0);
        chk({tag, "_res_busy"}, result, 32'd0);
      end
      if (i == 33) chk({tag, "_rdy_e33"}, {31'b0, ready}, 32'd1);
    end
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_exc", {31'b0, exception}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    chk("rst_hold_ready", {31'b0, ready}, 32'd0);

    run("m7q-3", 32'd7, 32'hFFFF_FFFD);
    chk("m7q-3_res", result, 32'hFFFF_FFEB);
    chk("m7q-3_exc", {31'b0, exception}, 32'd0);

    run("max_x2", 32'h7FFF_FFFF, 32'd2);
    chk("max_x2_res", result, 32'hFFFF_FFFE);
    chk("max_x2_exc", {31'b0, exception}, 32'd1);
`ifdef MULT_HI_EN
    chk("max_x2_hi", result_hi, 32'h0000_0000);
`endif

    run("min_xm1", 32'h8000_0000, 32'hFFFF_FFFF);
    chk("min_xm1_res", result, 32'h8000_0000);
    chk("min_xm1_exc", {31'b0, exception}, 32'd1);

    run("min_x1", 32'h8000_0000, 32'd1);
    chk("min_x1_res", result, 32'h8000_0000);
    chk("min_x1_exc", {31'b0, exception}, 32'd0);
`ifdef MULT_HI_EN
    chk("min_x1_hi", result_hi, 32'hFFFF_FFFF);
`endif

    run("min_xmin", 32'h8000_0000, 32'h8000_0000);
    chk("min_xmin_res", result, 32'h0000_0000);
    chk("min_xmin_exc", {31'b0, exception}, 32'd1);
`ifdef MULT_HI_EN
    chk("min_xmin_hi", result_hi, 32'h4000_0000);
`endif

    run("p16xp16", 32'h0001_0000, 32'h0001_0000);
    chk("p16_res", result, 32'h0000_0000);
    chk("p16_exc", {31'b0, exception}, 32'd1);
`ifdef MULT_HI_EN
    chk("p16_hi", result_hi, 32'h0000_0001);
`endif

    // Outputs must clear asynchronously when clr hits a finished result
    @(negedge clk); #2;
    clr = 1'b1;
    #1;
    chk("abort_done_ready", {31'b0, ready}, 32'd0);
    chk("abort_done_exc", {31'b0, exception}, 32'd0);

    // Abort mid-run after edge 10, hold clr for a few edges, then restart
    multiplicand = 32'd5;
    multiplier   = 32'd6;
    @(negedge clk);
    clr = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    clr = 1'b1;
    #1;
    chk("abort_mid_ready", {31'b0, ready}, 32'd0);
    chk("abort_mid_result", result, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("clr_hold_ready", {31'b0, ready}, 32'd0);
    run("m-4q-4", 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    chk("m-4q-4_res", result, 32'd16);
    chk("m-4q-4_exc", {31'b0, exception}, 32'd0);

    // Hold in DONE with changing operands
    multiplicand = 32'h1234_5678;
    multiplier   = 32'h9ABC_DEF0;
    repeat (10) @(posedge clk);
    #1;
    chk("done_hold_ready", {31'b0, ready}, 32'd1);
    chk("done_hold_res", result, 32'd16);

    run("m0", 32'd0, 32'hDEAD_BEEF);
    chk("m0_res", result, 32'd0);
    chk("m0_exc", {31'b0, exception}, 32'd0);

    run("q0", 32'h8000_0000, 32'd0);
    chk("q0_res", result, 32'd0);
    chk("q0_exc", {31'b0, exception}, 32'd0);

    run("neg_big", 32'hFFFF_0000, 32'h0001_0000);
    chk("neg_big_res", result, 32'h0000_0000);
    chk("neg_big_exc", {31'b0, exception}, 32'd1);
`ifdef MULT_HI_EN
    chk("neg_big_hi", result_hi, 32'hFFFF_FFFF);
`endif

    run("m1000q-1000", 32'd1000, 32'hFFFF_FC18);
    chk("m1000_res", result, 32'hFFF0_BDC0);
    chk("m1000_exc", {31'b0, exception}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
